mem_port_arbiter: RTL and testbench

//  Two-client front end for the single-port word memory. Merges instruction-side (c0) and data-side (c1)

---
 rtl/mem_port_arbiter.sv | 130 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Two-client front end for the single-port word memory. Client 0 (imem) and
//   client 1 (dmem) requests are merged onto the memory put channel with
//   round-robin arbitration. The issuing client of every accepted request is
//   recorded in an in-order tag FIFO, and each memory response is routed back
//   to the client at the FIFO head.
//
// Ports
//   CLK, RST                 clock, synchronous active-high reset
//   cK_req_valid/ready/req   client K request channel (K = 0, 1)
//   cK_resp_valid/ready/resp client K response channel
//   mem_put_valid/ready/request     request channel to memory
//   mem_get_ready/valid/response    response channel from memory
//                                   (mem_get_valid dequeues the response)
//   err_orphan               sticky flag: response offered with no tag outstanding
//
// Ops are {byte_en[3:0], addr[31:0], data[31:0]}; byte_en == 0 is a read.

module mem_port_arbiter #(
  parameter int OP_W      = 68,
  parameter int TAG_DEPTH = 4
) (
  input  logic            CLK,
  input  logic            RST,

  input  logic            c0_req_valid,
  output logic            c0_req_ready,
  input  logic [OP_W-1:0] c0_req,
  output logic            c0_resp_valid,
  input  logic            c0_resp_ready,
  output logic [OP_W-1:0] c0_resp,

  input  logic            c1_req_valid,
  output logic            c1_req_ready,
  input  logic [OP_W-1:0] c1_req,
  output logic            c1_resp_valid,
  input  logic            c1_resp_ready,
  output logic [OP_W-1:0] c1_resp,

  output logic            mem_put_valid,
  input  logic            mem_put_ready,
  output logic [OP_W-1:0] mem_put_request,
  input  logic            mem_get_ready,
  output logic            mem_get_valid,
  input  logic [OP_W-1:0] mem_get_response,

  output logic            err_orphan
);

  localparam int PTR_W = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(TAG_DEPTH);

  logic [TAG_DEPTH-1:0] tag_q;
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [CNT_W-1:0]     count;
  logic                 last_grant;

  logic full;
  logic empty;
  logic winner;
  logic head;
  logic push;
  logic pop;

  // Fullness comes from the registered count only: a pop in the same cycle
  // does not free a slot for a request until the next cycle.
  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign head  = tag_q[rd_ptr];

  // Round robin: on a tie the client that did not win last time goes next.
  always_comb begin
    winner = 1'b0;
    if (c0_req_valid && c1_req_valid) begin
      winner = ~last_grant;
    end else if (c1_req_valid) begin
      winner = 1'b1;
    end
  end

  // Handshake outputs are held low during reset so that neither clients nor
  // memory see a transfer that the cleared tag FIFO would not account for.
  assign mem_put_valid   = !RST && (c0_req_valid || c1_req_valid) && !full;
  assign mem_put_request = winner ? c1_req : c0_req;
  assign c0_req_ready    = !RST && !winner && mem_put_ready && !full;
  assign c1_req_ready    = !RST &&  winner && mem_put_ready && !full;

  // Response side uses only tag state and get-side inputs; memory put_ready
  // may depend on get_valid, so any put-side term here would form a loop.
  assign c0_resp_valid = !RST && !empty && !head && mem_get_ready;
  assign c1_resp_valid = !RST && !empty &&  head && mem_get_ready;
  assign c0_resp       = mem_get_response;
  assign c1_resp       = mem_get_response;
  assign mem_get_valid = !RST && !empty && mem_get_ready &&
                         (head ? c1_resp_ready : c0_resp_ready);

  assign push = mem_put_valid && mem_put_ready;
  assign pop  = mem_get_valid;

  always_ff @(posedge CLK) begin
    if (RST) begin
      tag_q      <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      last_grant <= 1'b1;
      err_orphan <= 1'b0;
    end else begin
      if (push) begin
        tag_q[wr_ptr] <= winner;
        wr_ptr        <= wr_ptr + PTR_W'(1);
        last_grant    <= winner;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (mem_get_ready && empty) begin
        err_orphan <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam int OP_W = 68;

  logic            CLK;
  logic            RST;
  logic            c0_req_valid, c0_req_ready, c0_resp_valid, c0_resp_ready;
  logic            c1_req_valid, c1_req_ready, c1_resp_valid, c1_resp_ready;
  logic [OP_W-1:0] c0_req, c0_resp, c1_req, c1_resp;
  logic            mem_put_valid, mem_put_ready, mem_get_ready, mem_get_valid;
  logic [OP_W-1:0] mem_put_request, mem_get_response;
  logic            err_orphan;

  int n_err;
  int n_checks;

  mem_port_arbiter #(.OP_W(OP_W), .TAG_DEPTH(4)) dut (
    .CLK              (CLK),
    .RST              (RST),
    .c0_req_valid     (c0_req_valid),
    .c0_req_ready     (c0_req_ready),
    .c0_req           (c0_req),
    .c0_resp_valid    (c0_resp_valid),
    .c0_resp_ready    (c0_resp_ready),
    .c0_resp          (c0_resp),
    .c1_req_valid     (c1_req_valid),
    .c1_req_ready     (c1_req_ready),
    .c1_req           (c1_req),
    .c1_resp_valid    (c1_resp_valid),
    .c1_resp_ready    (c1_resp_ready),
    .c1_resp          (c1_resp),
    .mem_put_valid    (mem_put_valid),
    .mem_put_ready    (mem_put_ready),
    .mem_put_request  (mem_put_request),
    .mem_get_ready    (mem_get_ready),
    .mem_get_valid    (mem_get_valid),
    .mem_get_response (mem_get_response),
    .err_orphan       (err_orphan)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // inputs:   c0v c1v put_ready get_ready r0 r1
  // expected: c0_req_ready c1_req_ready put_valid get_valid rv0 rv1 winner
  typedef struct packed {
    logic c0v, c1v, pr, gr, r0, r1;
    logic e_c0r, e_c1r, e_pv, e_gv, e_rv0, e_rv1, e_win;
  } vec_t;

  localparam int NV = 16;
  vec_t vecs [NV];

  localparam logic [OP_W-1:0] C0_OP = {4'h0, 32'h0000_0100, 32'h0000_0000};
  localparam logic [OP_W-1:0] C1_OP = {4'hF, 32'h0000_2000, 32'h1234_5678};

  task automatic chk(input string name, input logic [OP_W-1:0] act,
                     input logic [OP_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic a, input logic b, input logic pr,
                      input logic gr, input logic r0, input logic r1);
    @(negedge CLK);
    c0_req_valid  = a;
    c1_req_valid  = b;
    mem_put_ready = pr;
    mem_get_ready = gr;
    c0_resp_ready = r0;
    c1_resp_ready = r1;
    #1;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b1;
    c0_req_valid = 0; c1_req_valid = 0; mem_put_ready = 0;
    mem_get_ready = 0; c0_resp_ready = 0; c1_resp_ready = 0;
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic chk_hs_zero(input string tag);
    chk({tag, " c0_req_ready"},  c0_req_ready,  0);
    chk({tag, " c1_req_ready"},  c1_req_ready,  0);
    chk({tag, " mem_put_valid"}, mem_put_valid, 0);
    chk({tag, " mem_get_valid"}, mem_get_valid, 0);
    chk({tag, " c0_resp_valid"}, c0_resp_valid, 0);
    chk({tag, " c1_resp_valid"}, c1_resp_valid, 0);
  endtask

  initial begin
    n_err = 0;
    n_checks = 0;
    RST = 1'b1;
    c0_req = C0_OP;
    c1_req = C1_OP;
    mem_get_response = {36'h0, 32'hA5A5_0000};
    c0_req_valid = 0; c1_req_valid = 0; mem_put_ready = 0;
    mem_get_ready = 0; c0_resp_ready = 0; c1_resp_ready = 0;

    // Sequence from reset: single c0 request, its response, then
    // alternating ties up to full, stalls, and in-order draining.
    vecs[0]  = 13'b101000_1010000;
    vecs[1]  = 13'b000110_0001100;
    vecs[2]  = 13'b111000_0110001;
    vecs[3]  = 13'b111000_1010000;
    vecs[4]  = 13'b111000_0110001;
    vecs[5]  = 13'b111000_1010000;
    vecs[6]  = 13'b111000_0000000;
    vecs[7]  = 13'b111111_0001010;
    vecs[8]  = 13'b111111_0111101;
    vecs[9]  = 13'b000101_0001010;
    vecs[10] = 13'b000101_0000100;
    vecs[11] = 13'b000111_0001100;
    vecs[12] = 13'b000111_0001010;
    vecs[13] = 13'b000000_0000000;
    vecs[14] = 13'b100000_0010000;
    vecs[15] = 13'b011000_0110001;

    // reset state
    do_reset();
    step(0, 0, 0, 0, 0, 0);
    chk_hs_zero("reset");
    chk("reset err_orphan", err_orphan, 0);

    for (int i = 0; i < NV; i++) begin
      @(negedge CLK);
      c0_req_valid  = vecs[i].c0v;
      c1_req_valid  = vecs[i].c1v;
      mem_put_ready = vecs[i].pr;
      mem_get_ready = vecs[i].gr;
      c0_resp_ready = vecs[i].r0;
      c1_resp_ready = vecs[i].r1;
      mem_get_response = {36'h0, 32'hA5A5_0000 + 32'(i)};
      #1;
      chk($sformatf("v%0d c0_req_ready", i),  c0_req_ready,  vecs[i].e_c0r);
      chk($sformatf("v%0d c1_req_ready", i),  c1_req_ready,  vecs[i].e_c1r);
      chk($sformatf("v%0d mem_put_valid", i), mem_put_valid, vecs[i].e_pv);
      chk($sformatf("v%0d mem_get_valid", i), mem_get_valid, vecs[i].e_gv);
      chk($sformatf("v%0d c0_resp_valid", i), c0_resp_valid, vecs[i].e_rv0);
      chk($sformatf("v%0d c1_resp_valid", i), c1_resp_valid, vecs[i].e_rv1);
      if (vecs[i].e_pv)
        chk($sformatf("v%0d mem_put_request", i), mem_put_request,
            vecs[i].e_win ? C1_OP : C0_OP);
      if (vecs[i].e_rv0)
        chk($sformatf("v%0d c0_resp", i), c0_resp, {36'h0, 32'hA5A5_0000 + 32'(i)});
      if (vecs[i].e_rv1)
        chk($sformatf("v%0d c1_resp", i), c1_resp, {36'h0, 32'hA5A5_0000 + 32'(i)});
    end

    // Full FIFO: pop in the same cycle as a request does not admit it.
    do_reset();
    mem_get_response = {36'h0, 32'hBEEF_0001};
    for (int k = 0; k < 4; k++) begin
      step(0, 1, 1, 0, 0, 0);
      chk($sformatf("full fill%0d c1_req_ready", k), c1_req_ready, 1);
      chk($sformatf("full fill%0d put_request", k), mem_put_request, C1_OP);
    end
    step(0, 1, 1, 0, 0, 0);
    chk("full 5th c1_req_ready",  c1_req_ready,  0);
    chk("full 5th mem_put_valid", mem_put_valid, 0);
    step(0, 1, 1, 1, 0, 1);
    chk("full pop c1_req_ready",  c1_req_ready,  0);
    chk("full pop mem_get_valid", mem_get_valid, 1);
    chk("full pop c1_resp_valid", c1_resp_valid, 1);
    chk("full pop c0_resp_valid", c0_resp_valid, 0);
    chk("full pop c1_resp",       c1_resp, {36'h0, 32'hBEEF_0001});
    step(0, 1, 1, 0, 0, 0);
    chk("full after pop c1_req_ready", c1_req_ready, 1);
    step(0, 1, 1, 0, 0, 0);
    chk("full refilled c1_req_ready", c1_req_ready, 0);

    // Stalled head client blocks the other client's response.
    do_reset();
    step(1, 0, 1, 0, 0, 0);
    chk("hol c0 issue", c0_req_ready, 1);
    step(0, 1, 1, 0, 0, 0);
    chk("hol c1 issue", c1_req_ready, 1);
    for (int k = 0; k < 3; k++) begin
      step(0, 0, 0, 1, 0, 1);
      chk($sformatf("hol stall%0d mem_get_valid", k), mem_get_valid, 0);
      chk($sformatf("hol stall%0d c1_resp_valid", k), c1_resp_valid, 0);
      chk($sformatf("hol stall%0d c0_resp_valid", k), c0_resp_valid, 1);
    end
    step(0, 0, 0, 1, 1, 1);
    chk("hol c0 take mem_get_valid", mem_get_valid, 1);
    chk("hol c0 take c0_resp_valid", c0_resp_valid, 1);
    step(0, 0, 0, 1, 0, 1);
    chk("hol c1 take c1_resp_valid", c1_resp_valid, 1);
    chk("hol c1 take c0_resp_valid", c0_resp_valid, 0);
    chk("hol c1 take mem_get_valid", mem_get_valid, 1);

    // Orphan response is not dequeued and sets a sticky flag.
    do_reset();
    step(0, 0, 0, 1, 1, 1);
    chk("orphan mem_get_valid", mem_get_valid, 0);
    chk("orphan c0_resp_valid", c0_resp_valid, 0);
    chk("orphan c1_resp_valid", c1_resp_valid, 0);
    chk("orphan err before edge", err_orphan, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("orphan err set", err_orphan, 1);
    repeat (3) step(0, 0, 0, 0, 0, 0);
    chk("orphan err sticky", err_orphan, 1);
    do_reset();
    step(0, 0, 0, 0, 0, 0);
    chk("orphan err cleared by reset", err_orphan, 0);

    // Reset mid-operation with three requests outstanding.
    do_reset();
    for (int k = 0; k < 3; k++) begin
      step(1, 0, 1, 0, 0, 0);
      chk($sformatf("rst issue%0d c0_req_ready", k), c0_req_ready, 1);
    end
    @(negedge CLK);
    RST = 1'b1;
    c0_req_valid = 1; c1_req_valid = 1; mem_put_ready = 1;
    mem_get_ready = 1; c0_resp_ready = 1; c1_resp_ready = 1;
    #1;
    chk_hs_zero("in reset 1");
    @(negedge CLK);
    #1;
    chk_hs_zero("in reset 2");
    chk("in reset err_orphan", err_orphan, 0);
    @(negedge CLK);
    RST = 1'b0;
    c0_req_valid = 0; c1_req_valid = 0; mem_put_ready = 0;
    mem_get_ready = 1; c0_resp_ready = 0; c1_resp_ready = 0;
    #1;
    chk("post reset mem_get_valid", mem_get_valid, 0);
    chk("post reset c0_resp_valid", c0_resp_valid, 0);
    step(1, 1, 1, 0, 0, 0);
    chk("post reset empty (orphan)", err_orphan, 1);
    chk("post reset tie c0_req_ready", c0_req_ready, 1);
    chk("post reset tie c1_req_ready", c1_req_ready, 0);
    chk("post reset tie put_request", mem_put_request, C0_OP);
    step(1, 1, 1, 0, 0, 0);
    chk("post reset 2nd tie c1_req_ready", c1_req_ready, 1);
    chk("post reset 2nd tie c0_req_ready", c0_req_ready, 0);
    step(0, 0, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
